pixel_fetch: RTL and testbench

Parametrised framebuffer fetch engine for the HUB75 matrix driver. On each pixel-load request from the matrix scanner it reads one pixel per scan section (top/bottom halves by default, up to any power-of-two section count) from the synchronous framebuffer RAM. It presents all section pixels together with a one-cycle valid strobe. It sits between `matrix_scan`/`framebuffer` and the `rgb565`/`brightness` stages. It replaces ad-hoc negedge address/latch sequencing with a single-edge state machine whose RAM latency and geometry are parameters.

---
 rtl/pixel_fetch.sv | 142 ++++++++++++++
 tb/tb_pixel_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch.sv
// pixel_fetch: framebuffer fetch engine for the HUB75 matrix driver.
// Each accepted request reads one pixel per scan section from a synchronous
// RAM with a configurable read latency. All section pixels are then presented
// together on `pixels`, with a one-cycle `valid` strobe.
// Optional build macro PIXEL_FETCH_MIRROR_EN: the column field of `ram_addr` is
// inverted, for panels wired right-to-left. When it is not defined, the column
// is used as captured.
module pixel_fetch #(
    parameter int COLUMN_BITS  = 6,
    parameter int ROW_BITS     = 4,
    parameter int SECTION_BITS = 1,
    parameter int PIXEL_WIDTH  = 16,
    parameter int RAM_LATENCY  = 2
) (
    input  logic                                          clk_in,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [COLUMN_BITS-1:0]                        column_address,
    input  logic [ROW_BITS-1:0]                           row_address,
    output logic [SECTION_BITS+ROW_BITS+COLUMN_BITS-1:0]  ram_addr,
    output logic                                          ram_clk_en,
    input  logic [PIXEL_WIDTH-1:0]                        ram_data,
    output logic [(1<<SECTION_BITS)*PIXEL_WIDTH-1:0]      pixels,
    output logic                                          valid,
    output logic                                          busy,
    output logic                                          overrun
);

    localparam int NSEC   = 1 << SECTION_BITS;
    localparam int AW     = SECTION_BITS + ROW_BITS + COLUMN_BITS;
    // The section counter needs at least one bit, even when there is a single section.
    localparam int SEC_W  = (SECTION_BITS > 0) ? SECTION_BITS : 1;
    localparam int WAIT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(RAM_LATENCY - 1);
    localparam logic [SEC_W-1:0]  LAST_SEC    = SEC_W'(NSEC - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                         state_q;
    logic [SEC_W-1:0]               sec_q;
    logic [WAIT_W-1:0]              wait_q;
    logic [ROW_BITS-1:0]            row_q;
    logic [COLUMN_BITS-1:0]         col_q;
    logic [AW-1:0]                  addr_q;
    logic [NSEC*PIXEL_WIDTH-1:0]    stage_q;
    logic [NSEC*PIXEL_WIDTH-1:0]    pixels_q;
    logic                           valid_q;
    logic                           busy_q;
    logic                           overrun_q;

    logic [AW-1:0]                  accept_addr_d;
    logic [AW-1:0]                  advance_addr_d;
    logic [NSEC*PIXEL_WIDTH-1:0]    pixels_d;

    // Build the RAM address {section, row, column}. With a single section,
    // the section bit is dropped by keeping only the low AW bits.
    function automatic logic [AW-1:0] form_addr(
        input logic [SEC_W-1:0]       sec,
        input logic [ROW_BITS-1:0]    row,
        input logic [COLUMN_BITS-1:0] col
    );
        logic [SEC_W+ROW_BITS+COLUMN_BITS-1:0] full;
`ifdef PIXEL_FETCH_MIRROR_EN
        full = {sec, row, ~col};
`else
        full = {sec, row, col};
`endif
        return full[AW-1:0];
    endfunction

    // Compute the address loaded on accept and on each section advance.
    // Also compute the final pixel word: the staged sections plus the sample arriving now.
    always_comb begin
        accept_addr_d  = form_addr('0, row_address, column_address);
        advance_addr_d = form_addr(sec_q + SEC_W'(1), row_q, col_q);
        pixels_d       = stage_q;
        pixels_d[(NSEC-1)*PIXEL_WIDTH +: PIXEL_WIDTH] = ram_data;
    end

    // Fetch state machine. All outputs are registered here.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sec_q     <= '0;
            wait_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            stage_q   <= '0;
            pixels_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_q   <= row_address;
                        col_q   <= column_address;
                        addr_q  <= accept_addr_d;
                        sec_q   <= '0;
                        wait_q  <= WAIT_RELOAD;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    // A request arriving mid-fetch is dropped. The drop is remembered until reset.
                    if (start) begin
                        overrun_q <= 1'b1;
                    end
                    if (wait_q != '0) begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end else if (sec_q == LAST_SEC) begin
                        // Publish all sections at once, so partial data is never visible.
                        pixels_q <= pixels_d;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        stage_q[int'(sec_q)*PIXEL_WIDTH +: PIXEL_WIDTH] <= ram_data;
                        sec_q  <= sec_q + SEC_W'(1);
                        addr_q <= advance_addr_d;
                        wait_q <= WAIT_RELOAD;
                    end
                end
            endcase
        end
    end

    assign ram_addr   = addr_q;
    assign ram_clk_en = busy_q;
    assign pixels     = pixels_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pixel_fetch.sv
// Testbench for pixel_fetch. It runs two instances:
//   A: default geometry (2 sections, RAM latency 2)
//   B: 4 sections, RAM latency 3
// Each has a RAM model that returns data = address after the configured latency.
// Expected pixel words go into a per-instance scoreboard queue at accept time,
// and are checked when `valid` is seen.
module tb_pixel_fetch;

    localparam int CB = 6;
    localparam int RB = 4;
`ifdef PIXEL_FETCH_MIRROR_EN
    localparam logic [CB-1:0] CMASK = '1;
`else
    localparam logic [CB-1:0] CMASK = '0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] qa[$];
    logic [63:0] qb[$];

    // Instance A
    logic          a_start;
    logic [CB-1:0] a_col;
    logic [RB-1:0] a_row;
    logic [10:0]   a_addr;
    logic          a_ce;
    logic [15:0]   a_rd;
    logic [31:0]   a_pix;
    logic          a_valid, a_busy, a_ovr;

    pixel_fetch #(.COLUMN_BITS(6), .ROW_BITS(4), .SECTION_BITS(1),
                  .PIXEL_WIDTH(16), .RAM_LATENCY(2)) dut_a (
        .clk_in(clk), .reset(rst_n), .start(a_start),
        .column_address(a_col), .row_address(a_row),
        .ram_addr(a_addr), .ram_clk_en(a_ce), .ram_data(a_rd),
        .pixels(a_pix), .valid(a_valid), .busy(a_busy), .overrun(a_ovr));

    // RAM model for latency 2: one registered read stage.
    always_ff @(posedge clk) a_rd <= {5'd0, a_addr};

    // Instance B
    logic          b_start;
    logic [CB-1:0] b_col;
    logic [RB-1:0] b_row;
    logic [11:0]   b_addr;
    logic          b_ce;
    logic [15:0]   b_rd;
    logic [11:0]   b_d1;
    logic [63:0]   b_pix;
    logic          b_valid, b_busy, b_ovr;

    pixel_fetch #(.COLUMN_BITS(6), .ROW_BITS(4), .SECTION_BITS(2),
                  .PIXEL_WIDTH(16), .RAM_LATENCY(3)) dut_b (
        .clk_in(clk), .reset(rst_n), .start(b_start),
        .column_address(b_col), .row_address(b_row),
        .ram_addr(b_addr), .ram_clk_en(b_ce), .ram_data(b_rd),
        .pixels(b_pix), .valid(b_valid), .busy(b_busy), .overrun(b_ovr));

    // RAM model for latency 3: two register stages.
    always_ff @(posedge clk) begin
        b_d1 <= b_addr;
        b_rd <= {4'd0, b_d1};
    end

    // Reference address: {section, row, column (inverted when mirrored)}.
    function automatic logic [11:0] exp_addr(input int sec, input logic [RB-1:0] row,
                                             input logic [CB-1:0] col);
        return (12'(sec) << 10) | (12'(row) << 6) | 12'(col ^ CMASK);
    endfunction

    // Read an output of instance dut.
    // what: 0 valid, 1 busy, 2 clk_en, 3 overrun, 4 addr, 5 pixels.
    function automatic logic [63:0] obs(input int dut, input int what);
        logic [63:0] r;
        r = '0;
        case (what)
            0: r = (dut == 0) ? 64'(a_valid) : 64'(b_valid);
            1: r = (dut == 0) ? 64'(a_busy)  : 64'(b_busy);
            2: r = (dut == 0) ? 64'(a_ce)    : 64'(b_ce);
            3: r = (dut == 0) ? 64'(a_ovr)   : 64'(b_ovr);
            4: r = (dut == 0) ? 64'(a_addr)  : 64'(b_addr);
            default: r = (dut == 0) ? 64'(a_pix) : b_pix;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int dut, input logic s, input logic [RB-1:0] r,
                             input logic [CB-1:0] c);
        if (dut == 0) begin
            a_start = s; a_row = r; a_col = c;
        end else begin
            b_start = s; b_row = r; b_col = c;
        end
    endtask

    // Issue one fetch and follow it to `valid`.
    // pulse_at > 0 re-asserts start so that it is sampled at accept edge + pulse_at.
    task automatic run_fetch(input int dut, input logic [RB-1:0] row,
                             input logic [CB-1:0] col, input int pulse_at);
        int          nsec, rl, lat;
        logic [63:0] ep, e;
        bit          seen;
        nsec = (dut == 0) ? 2 : 4;
        rl   = (dut == 0) ? 2 : 3;
        lat  = nsec * rl;
        ep   = '0;
        for (int s = 0; s < nsec; s++) ep |= 64'(exp_addr(s, row, col)) << (16 * s);
        set_start(dut, 1'b1, row, col);
        tick;
        if (dut == 0) qa.push_back(ep); else qb.push_back(ep);
        // Changing the request inputs after accept must have no effect.
        set_start(dut, 1'b0, ~row, ~col);
        check("accept_busy", obs(dut, 1), 64'(1));
        check("accept_valid", obs(dut, 0), 64'(0));
        check("addr_s0", obs(dut, 4), 64'(exp_addr(0, row, col)));
        seen = 1'b0;
        for (int c = 1; c <= lat + 2 && !seen; c++) begin
            if (c == pulse_at) set_start(dut, 1'b1, ~row, ~col);
            tick;
            if (c == pulse_at) set_start(dut, 1'b0, ~row, ~col);
            if (obs(dut, 0) == 64'(1)) begin
                seen = 1'b1;
                check("latency", 64'(c), 64'(lat));
                check("busy_at_valid", obs(dut, 1), 64'(0));
                check("addr_hold_last", obs(dut, 4), 64'(exp_addr(nsec - 1, row, col)));
                if (dut == 0) e = (qa.size() > 0) ? qa.pop_front() : '1;
                else          e = (qb.size() > 0) ? qb.pop_front() : '1;
                check("pixels", obs(dut, 5), e);
                $display("fetch dut=%0d row=%0h col=%0h pixels=%0h latency=%0d", dut, row, col,
                         obs(dut, 5), c);
            end else begin
                check("busy_in_fetch", obs(dut, 1), 64'(1));
                if (c < lat) check("addr_seq", obs(dut, 4), 64'(exp_addr(c / rl, row, col)));
            end
            check("ce_eq_busy", obs(dut, 2), obs(dut, 1));
        end
        check("valid_seen", 64'(seen), 64'(1));
    endtask

    initial begin
        logic [63:0] last_a;
        rst_n = 1'b0;
        set_start(0, 1'b1, 4'd5, 6'd10);
        set_start(1, 1'b0, 4'd0, 6'd0);
        repeat (3) tick;
        // While reset is held, all outputs stay zero even though start is high.
        check("rst_a_addr", 64'(a_addr), 64'(0));
        check("rst_a_pix", 64'(a_pix), 64'(0));
        check("rst_a_valid", 64'(a_valid), 64'(0));
        check("rst_a_busy", 64'(a_busy), 64'(0));
        check("rst_a_ce", 64'(a_ce), 64'(0));
        check("rst_a_ovr", 64'(a_ovr), 64'(0));
        check("rst_b_pix", b_pix, 64'(0));
        check("rst_b_addr", 64'(b_addr), 64'(0));
        rst_n = 1'b1;

        // First fetch is accepted on the first edge after release.
        run_fetch(0, 4'd5, 6'd10, -1);
        // Start during the valid cycle is accepted and does not count as an overrun.
        run_fetch(0, 4'hA, 6'h15, -1);
        check("no_overrun_b2b", 64'(a_ovr), 64'(0));
        last_a = 64'(a_pix);
        repeat (3) tick;
        check("pixels_hold", 64'(a_pix), last_a);
        check("idle_valid", 64'(a_valid), 64'(0));

        // Start pulsed two cycles after accept: the result is unchanged and overrun becomes sticky.
        run_fetch(0, 4'd3, 6'd33, 2);
        check("overrun_set", 64'(a_ovr), 64'(1));
        repeat (4) tick;
        check("overrun_sticky", 64'(a_ovr), 64'(1));
        run_fetch(0, 4'hF, 6'h3F, -1);
        check("overrun_still", 64'(a_ovr), 64'(1));

        // Four sections with RAM latency 3.
        run_fetch(1, 4'd7, 6'd42, -1);
        run_fetch(1, 4'hF, 6'h00, -1);
        check("b_no_overrun", 64'(b_ovr), 64'(0));

        // Reset asserted in cycle 3 of a fetch aborts it immediately.
        set_start(1, 1'b1, 4'd9, 6'd17);
        tick;
        set_start(1, 1'b0, 4'd0, 6'd0);
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(b_busy), 64'(0));
        check("abort_valid", 64'(b_valid), 64'(0));
        check("abort_pix", b_pix, 64'(0));
        check("abort_addr", 64'(b_addr), 64'(0));
        check("abort_a_ovr", 64'(a_ovr), 64'(0));
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick;
            check("no_valid_after_abort", 64'(b_valid), 64'(0));
        end
        run_fetch(1, 4'd2, 6'd5, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
